// File: rtl/mips_fetch_stage_if.sv
// Fetch-stage bundle: control from hazard/branch logic, the instruction-memory bus,
// and the IF/ID register outputs feeding decode.
interface mips_fetch_stage_if #(
   parameter int CNT_W = 32
);
   logic             pcen;
   logic             stall;
   logic             flush;
   logic             redirect;
   logic [31:0]      redirect_pc;
   logic [31:0]      imem_addr;
   logic [31:0]      imem_rdata;
   logic [31:0]      ifid_instr;
   logic [31:0]      ifid_pcplus4;
   logic             ifid_valid;
   logic [CNT_W-1:0] counterIF;
   logic             misalign_err;

   modport master (
      input  pcen, stall, flush, redirect, redirect_pc, imem_rdata,
      output imem_addr, ifid_instr, ifid_pcplus4, ifid_valid, counterIF, misalign_err
   );

   modport slave (
      output pcen, stall, flush, redirect, redirect_pc, imem_rdata,
      input  imem_addr, ifid_instr, ifid_pcplus4, ifid_valid, counterIF, misalign_err
   );
endinterface

// File: rtl/mips_fetch_stage.sv
// MIPS IF stage: owns the PC and the IF/ID register, applies pcen/stall/redirect/flush
// priority and keeps the fetched-instruction count plus a sticky misaligned-target flag.
module mips_fetch_stage #(
   parameter logic [31:0] PC_RESET  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int          CNT_W     = 32
) (
   input logic               clk,
   input logic               reset,
   mips_fetch_stage_if.master bus
);

   logic [31:0]      pc_p0;
   logic [31:0]      pcplus4_p0;
   logic [31:0]      instr_p1;
   logic [31:0]      pcplus4_p1;
   logic             vld_p1;
   logic [CNT_W-1:0] cnt_p1;
   logic             misalign_p1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign pcplus4_p0 = pc_p0 + 32'd4;

   // p0 -> p1: PC update and IF/ID load, first matching rule wins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_p0       <= {PC_RESET[31:2], 2'b00};
         instr_p1    <= NOP_INSTR;
         pcplus4_p1  <= 32'd0;
         vld_p1      <= 1'b0;
         cnt_p1      <= '0;
         misalign_p1 <= 1'b0;
      end else if (!bus.pcen) begin
         instr_p1   <= NOP_INSTR;
         pcplus4_p1 <= 32'd0;
         vld_p1     <= 1'b0;
      end else if (bus.stall) begin
         // the ID instruction raising redirect is stalled too, so redirect waits
         if (bus.flush) begin
            instr_p1   <= NOP_INSTR;
            pcplus4_p1 <= 32'd0;
            vld_p1     <= 1'b0;
         end
      end else if (bus.redirect) begin
         pc_p0      <= {bus.redirect_pc[31:2], 2'b00};
         instr_p1   <= NOP_INSTR;
         pcplus4_p1 <= 32'd0;
         vld_p1     <= 1'b0;
         if (bus.redirect_pc[1:0] != 2'b00) misalign_p1 <= 1'b1;
      end else if (bus.flush) begin
         pc_p0      <= pcplus4_p0;
         instr_p1   <= NOP_INSTR;
         pcplus4_p1 <= 32'd0;
         vld_p1     <= 1'b0;
      end else begin
         pc_p0      <= pcplus4_p0;
         instr_p1   <= bus.imem_rdata;
         pcplus4_p1 <= pcplus4_p0;
         vld_p1     <= 1'b1;
         cnt_p1     <= sat_inc(cnt_p1);
      end
   end

   assign bus.imem_addr    = pc_p0;
   assign bus.ifid_instr   = instr_p1;
   assign bus.ifid_pcplus4 = pcplus4_p1;
   assign bus.ifid_valid   = vld_p1;
   assign bus.counterIF    = cnt_p1;
   assign bus.misalign_err = misalign_p1;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Scoreboard bench for mips_fetch_stage: a reference model predicts each edge's state,
// plus a CNT_W=3 instance for counter saturation.
module tb_mips_fetch_stage;

   logic clk = 1'b0;
   logic reset;
   logic rst_s;
   always #5 clk = ~clk;

   mips_fetch_stage_if #(.CNT_W(32)) bus ();
   mips_fetch_stage_if #(.CNT_W(3))  sbus ();

   mips_fetch_stage #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus.master));
   mips_fetch_stage #(.CNT_W(3))  dut_sat (.clk(clk), .reset(rst_s), .bus(sbus.master));

   logic [31:0] rom [64];
   assign bus.imem_rdata  = rom[bus.imem_addr[7:2]];
   assign sbus.imem_rdata = 32'h1234_5678;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] p4;
      logic        valid;
      logic [31:0] cnt;
      logic        mis;
   } exp_t;

   exp_t sb[$];
   int vectors = 0;
   int miscompares = 0;

   logic [31:0] m_pc, m_instr, m_p4, m_cnt;
   logic        m_valid, m_mis;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      if (obs !== expv) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'd0; m_instr = 32'd0; m_p4 = 32'd0;
      m_valid = 1'b0; m_cnt = 32'd0; m_mis = 1'b0;
   endtask

   task automatic model_bubble();
      m_instr = 32'd0; m_p4 = 32'd0; m_valid = 1'b0;
   endtask

   // predict the next edge from current inputs, then compare after the edge
   task automatic step(input string tag);
      exp_t e;
      logic [31:0] fetched;
      fetched = rom[m_pc[7:2]];
      if (bus.pcen === 1'b0) model_bubble();
      else if (bus.stall) begin
         if (bus.flush) model_bubble();
      end else if (bus.redirect) begin
         if (bus.redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
         m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
         model_bubble();
      end else if (bus.flush) begin
         m_pc = m_pc + 32'd4;
         model_bubble();
      end else begin
         m_instr = fetched;
         m_p4 = m_pc + 32'd4;
         m_valid = 1'b1;
         m_pc = m_pc + 32'd4;
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
      e = '{addr: m_pc, instr: m_instr, p4: m_p4, valid: m_valid, cnt: m_cnt, mis: m_mis};
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, ".addr"},  bus.imem_addr,            e.addr);
      chk({tag, ".instr"}, bus.ifid_instr,           e.instr);
      chk({tag, ".p4"},    bus.ifid_pcplus4,         e.p4);
      chk({tag, ".valid"}, {31'd0, bus.ifid_valid},  {31'd0, e.valid});
      chk({tag, ".cnt"},   bus.counterIF,            e.cnt);
      chk({tag, ".mis"},   {31'd0, bus.misalign_err}, {31'd0, e.mis});
   endtask

   task automatic set_in(input logic pe, input logic st, input logic fl,
                         input logic rd, input logic [31:0] rpc);
      bus.pcen = pe; bus.stall = st; bus.flush = fl;
      bus.redirect = rd; bus.redirect_pc = rpc;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".addr"},  bus.imem_addr,            32'd0);
      chk({tag, ".instr"}, bus.ifid_instr,           32'd0);
      chk({tag, ".p4"},    bus.ifid_pcplus4,         32'd0);
      chk({tag, ".valid"}, {31'd0, bus.ifid_valid},  32'd0);
      chk({tag, ".cnt"},   bus.counterIF,            32'd0);
      chk({tag, ".mis"},   {31'd0, bus.misalign_err}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 | (i << 2);
      rom[0] = 32'h2008_0005;
      reset = 1'b1;
      rst_s = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      sbus.pcen = 1'b1; sbus.stall = 1'b0; sbus.flush = 1'b0;
      sbus.redirect = 1'b0; sbus.redirect_pc = 32'd0;
      model_reset();

      #20;
      chk_reset_vals("rst_hold");
      #30;
      reset = 1'b0;

      step("pcen0_a");
      step("pcen0_b");
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      step("first");
      chk("first_instr", bus.ifid_instr, 32'h2008_0005);
      for (int i = 0; i < 4; i++) step("seq");
      chk("seq_addr", bus.imem_addr, 32'd20);
      chk("seq_cnt",  bus.counterIF, 32'd5);
      chk("seq_p4",   bus.ifid_pcplus4, 32'd20);

      set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0080);
      step("pcen0_ignores_redir");
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0008);
      step("redir8");
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      step("adv_fill");
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0040);
      step("stall_redir_a");
      step("stall_redir_b");
      chk("stall_pc", bus.imem_addr, 32'h0000_000C);
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
      step("redir40");
      chk("redir40_pc", bus.imem_addr, 32'h0000_0040);

      set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      step("adv44");
      set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
      step("stall_flush");
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
      step("flush_only");
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0102);
      step("misalign");
      chk("misalign_pc", bus.imem_addr, 32'h0000_0100);
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 10; i++) step("sticky");
      chk("sticky_mis", {31'd0, bus.misalign_err}, 32'd1);

      set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      step("redir_top");
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      step("wrap");
      chk("wrap_p4", bus.ifid_pcplus4, 32'd0);
      chk("wrap_pc", bus.imem_addr, 32'd0);
      step("post_wrap");

      #3;
      reset = 1'b1;
      #1;
      chk_reset_vals("async_rst");
      model_reset();
      #2;
      reset = 1'b0;
      step("restart");

      // saturation on the 3-bit counter instance
      @(negedge clk);
      rst_s = 1'b0;
      for (int i = 1; i <= 11; i++) begin
         @(posedge clk);
         #1;
         chk("sat_cnt", {29'd0, sbus.counterIF}, (i > 7) ? 32'd7 : i);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
